// File: rtl/rasterizer_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rasterizer_mem_arbiter
// Purpose  : N-to-1 Avalon-MM round-robin arbiter with in-order read routing.
// Revision : 1.0  initial release
// ============================================================================
module rasterizer_mem_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8,
  localparam int BE_W       = DATA_W / 8,
  localparam int c_CNT_W    = $clog2(MAX_PENDING) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_read,
  output logic                          s_write,
  output logic [BE_W-1:0]               s_byteenable,
  output logic [DATA_W-1:0]             s_writedata,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  output logic [c_CNT_W-1:0]            pending_count,
  output logic                          rsp_error
);

  localparam int c_PTR_W = $clog2(MAX_PENDING);
  localparam int c_GNT_W = $clog2(NUM_MASTERS);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(MAX_PENDING);
  localparam logic [c_GNT_W-1:0] c_LAST = c_GNT_W'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_GNT_W-1:0]   r_gnt;
  logic [c_GNT_W-1:0]   r_rr_ptr;
  logic [c_GNT_W-1:0]   w_pick;
  logic                 w_found;
  logic                 w_load;
  logic                 w_accept;
  logic [NUM_MASTERS-1:0] w_elig;

  logic [c_GNT_W-1:0]   r_tag_mem [MAX_PENDING];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_rsp_error;
  logic [c_GNT_W-1:0]   w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_gnt_rd;
  logic                 w_gnt_wr;
  logic                 w_gnt_req;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  // Reads need a free tag slot; writes never produce a response.
  assign w_elig  = m_write | (m_read & {NUM_MASTERS{~w_full}});

  assign w_gnt_rd  = m_read[r_gnt];
  assign w_gnt_wr  = m_write[r_gnt] & ~m_read[r_gnt];
  assign w_gnt_req = m_read[r_gnt] | m_write[r_gnt];

  always_comb begin : p_pick
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = c_GNT_W'(idx);
      end
    end
  end

  always_comb begin : p_fsm
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_accept      = 1'b0;
    m_waitrequest = '1;
    s_address     = '0;
    s_byteenable  = '0;
    s_writedata   = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_load      = 1'b1;
        end
      end
      S_GRANT: begin
        s_address    = m_address[r_gnt*ADDR_W +: ADDR_W];
        s_byteenable = m_byteenable[r_gnt*BE_W +: BE_W];
        s_writedata  = m_writedata[r_gnt*DATA_W +: DATA_W];
        s_read       = w_gnt_rd & ~w_full;
        s_write      = w_gnt_wr;
        m_waitrequest[r_gnt] = (w_gnt_rd & w_full) | s_waitrequest;
        w_accept     = (s_read | s_write) & ~s_waitrequest;
        if (!w_gnt_req || w_accept) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_gnt <= w_pick;
      if (w_accept) r_rr_ptr <= (r_gnt == c_LAST) ? '0 : r_gnt + 1'b1;
    end
  end

  // Tag FIFO: records the owner of every issued read so responses route in order.
  assign w_push = w_accept & s_read;
  assign w_pop  = s_readdatavalid & ~w_empty;
  assign w_head = r_tag_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s_readdatavalid && w_empty) r_rsp_error <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= r_gnt;
  end

  assign m_readdata      = s_readdata;
  assign m_readdatavalid = w_pop ? (NUM_MASTERS'(1) << w_head) : '0;
  assign pending_count   = r_count;
  assign rsp_error       = r_rsp_error;

endmodule
`default_nettype wire
